// File: rtl/dac_sample_serializer.sv
// Converts one signed 32-bit accumulator sample into a saturated offset-binary
// DAC code and shifts {CMD, code} out MSB first over SPI to a MAX5134.
module dac_sample_serializer #(
    parameter int          CLK_DIV   = 4,
    parameter logic [7:0]  CMD       = 8'b00110001,
    parameter int          OUT_SHIFT = 2
) (
    input  logic        fpga_clock,
    input  logic        rstn,
    input  logic [31:0] sample_in,
    input  logic        send,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow,
    output logic        dropped,
    output logic        spi_cs_out,
    output logic        spi_clock_out,
    output logic        spi_data_out
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        half, half_nxt;       // 0: SCLK-high half of a bit, 1: low half
    logic [4:0]  bit_idx, bit_nxt;
    logic [23:0] frame, frame_nxt;
    logic        ovf_nxt, drop_nxt, done_nxt;
    logic        active_nxt, sclk_nxt, data_nxt;
    logic        last;

    // 34-bit signed datapath so shift + offset never wraps before clamping
    logic signed [33:0] shifted, sum;
    logic [15:0]        code;
    logic               sat;

    assign shifted = $signed({{2{sample_in[31]}}, sample_in}) >>> OUT_SHIFT;
    assign sum     = shifted + 34'sd32768;
    assign sat     = sum[33] | (|sum[32:16]);
    assign code    = sum[33] ? 16'h0000 : ((|sum[32:16]) ? 16'hFFFF : sum[15:0]);
    assign last    = (cnt == DIV_LAST);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        half_nxt  = half;
        bit_nxt   = bit_idx;
        frame_nxt = frame;
        ovf_nxt   = 1'b0;
        drop_nxt  = send && (state != IDLE);
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (send) begin
                    state_nxt = SETUP;
                    cnt_nxt   = 8'd0;
                    half_nxt  = 1'b0;
                    bit_nxt   = 5'd23;
                    frame_nxt = {CMD, code};
                    ovf_nxt   = sat;
                end
            end
            SETUP: begin
                cnt_nxt = last ? 8'd0 : cnt + 8'd1;
                if (last) state_nxt = SHIFT;
            end
            SHIFT: begin
                cnt_nxt = last ? 8'd0 : cnt + 8'd1;
                if (last) begin
                    half_nxt = ~half;
                    if (half) begin
                        if (bit_idx == 5'd0) state_nxt = HOLD;
                        else                 bit_nxt   = bit_idx - 5'd1;
                    end
                end
            end
            HOLD: begin
                cnt_nxt = last ? 8'd0 : cnt + 8'd1;
                if (last) state_nxt = GAP;
            end
            GAP: begin
                cnt_nxt = last ? 8'd0 : cnt + 8'd1;
                if (last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs are registered from next-state values so pins never glitch;
        // data only moves at bit starts, which coincide with SCLK rising.
        active_nxt = (state_nxt == SETUP) || (state_nxt == SHIFT) || (state_nxt == HOLD);
        sclk_nxt   = !((state_nxt == SHIFT) && half_nxt);
        data_nxt   = active_nxt && frame_nxt[bit_nxt];
    end

    always_ff @(posedge fpga_clock or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            half    <= 1'b0;
            bit_idx <= 5'd0;
            frame   <= 24'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            half    <= half_nxt;
            bit_idx <= bit_nxt;
            frame   <= frame_nxt;
        end
    end

    always_ff @(posedge fpga_clock or negedge rstn) begin
        if (!rstn) begin
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
            dropped       <= 1'b0;
            spi_cs_out    <= 1'b1;
            spi_clock_out <= 1'b1;
            spi_data_out  <= 1'b0;
        end else begin
            busy          <= (state_nxt != IDLE);
            frame_done    <= done_nxt;
            overflow      <= ovf_nxt;
            dropped       <= drop_nxt;
            spi_cs_out    <= !active_nxt;
            spi_clock_out <= sclk_nxt;
            spi_data_out  <= data_nxt;
        end
    end

endmodule

// File: tb/tb_dac_sample_serializer.sv
// Directed bench: three serializers (CLK_DIV 4, 1, 7) with an SPI capture
// monitor that rebuilds frames on SCLK falling edges.
module tb_dac_sample_serializer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] sample_v [3];
    logic [2:0]  send_v;
    logic [2:0]  busy_v, done_v, ovf_v, drop_v, cs_v, sclk_v, data_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CD = (g == 0) ? 4 : ((g == 1) ? 1 : 7);
        dac_sample_serializer #(.CLK_DIV(CD)) u_dut (
            .fpga_clock    (clk),
            .rstn          (rstn),
            .sample_in     (sample_v[g]),
            .send          (send_v[g]),
            .busy          (busy_v[g]),
            .frame_done    (done_v[g]),
            .overflow      (ovf_v[g]),
            .dropped       (drop_v[g]),
            .spi_cs_out    (cs_v[g]),
            .spi_clock_out (sclk_v[g]),
            .spi_data_out  (data_v[g])
        );
    end

    int checks = 0;
    int errors = 0;

    // monitor state
    logic [23:0] shreg [3];
    logic [23:0] last_frame [3];
    int          nbits [3], frame_cnt [3], ovf_cnt [3], drop_cnt [3];
    int          busy_run [3], busy_len [3], viol [3];
    logic [2:0]  p_sclk = 3'b111, p_data = 3'b000, p_busy = 3'b000;

    initial begin
        for (int i = 0; i < 3; i++) begin
            shreg[i] = '0; last_frame[i] = '0; nbits[i] = 0; frame_cnt[i] = 0;
            ovf_cnt[i] = 0; drop_cnt[i] = 0; busy_run[i] = 0; busy_len[i] = 0; viol[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!cs_v[i]) begin
                if (p_sclk[i] && !sclk_v[i]) begin
                    shreg[i] = {shreg[i][22:0], data_v[i]};
                    nbits[i] = nbits[i] + 1;
                    if (nbits[i] == 24) begin
                        last_frame[i] = shreg[i];
                        frame_cnt[i]  = frame_cnt[i] + 1;
                    end
                end
                if ((data_v[i] != p_data[i]) && !sclk_v[i]) viol[i] = viol[i] + 1;
            end else begin
                nbits[i] = 0;
            end
            if (ovf_v[i])  ovf_cnt[i]  = ovf_cnt[i] + 1;
            if (drop_v[i]) drop_cnt[i] = drop_cnt[i] + 1;
            if (busy_v[i]) busy_run[i] = busy_run[i] + 1;
            else if (p_busy[i]) begin
                busy_len[i] = busy_run[i];
                busy_run[i] = 0;
            end
        end
        p_sclk = sclk_v;
        p_data = data_v;
        p_busy = busy_v;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int cd_of(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 1 : 7);
    endfunction

    function automatic logic [23:0] ref_frame(input logic [31:0] s);
        longint      v;
        logic [15:0] c;
        v = longint'($signed(s));
        v = (v >>> 2) + 32768;
        if (v < 0)          c = 16'h0000;
        else if (v > 65535) c = 16'hFFFF;
        else                c = 16'(v);
        return {8'h31, c};
    endfunction

    // Issues a one-cycle send; sample_in is scrambled right after acceptance.
    task automatic send_on(input int i, input logic [31:0] v);
        @(posedge clk); #1;
        send_v[i] = 1'b1; sample_v[i] = v;
        @(posedge clk); #1;
        send_v[i] = 1'b0; sample_v[i] = 32'hDEAD_BEEF;
    endtask

    // Returns at +1 inside the frame_done cycle, or flags a timeout.
    task automatic wait_done(input int i, input string name);
        bit hit = 0;
        for (int c = 0; c < 51 * cd_of(i) + 20; c++) begin
            @(posedge clk); #1;
            if (done_v[i]) begin hit = 1; break; end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: frame_done timeout got 0 expected 1", name);
        end
    endtask

    typedef struct {
        logic [31:0] sample;
        logic [23:0] frame;
        int          ovf;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int fc, dc;
        logic [31:0] v;
        vecs[0] = '{32'h0000_0000, 24'h318000, 0};
        vecs[1] = '{32'h0001_FFFC, 24'h31FFFF, 0};
        vecs[2] = '{32'h0002_0000, 24'h31FFFF, 1};
        vecs[3] = '{32'hFFFE_0000, 24'h310000, 0};
        vecs[4] = '{32'hFFFD_FFFC, 24'h310000, 1};
        vecs[5] = '{32'h8000_0000, 24'h310000, 1};
        vecs[6] = '{32'h0000_1234, 24'h31848D, 0};
        send_v = '0;
        for (int i = 0; i < 3; i++) sample_v[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {57'd0, cs_v[0], sclk_v[0], data_v[0], busy_v[0], done_v[0], ovf_v[0], drop_v[0]},
            64'b1100000);
        @(negedge clk) rstn = 1'b1;

        // table-driven frames on the CLK_DIV=4 instance
        for (int k = 0; k < 7; k++) begin
            ovf_cnt[0] = 0;
            fc = frame_cnt[0];
            send_on(0, vecs[k].sample);
            chk($sformatf("busy_after_accept[%0d]", k), {63'd0, busy_v[0]}, 64'd1);
            wait_done(0, $sformatf("vec%0d", k));
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("frame[%0d]", k), {40'd0, last_frame[0]}, {40'd0, vecs[k].frame});
            chk($sformatf("frame_cnt[%0d]", k), 64'(frame_cnt[0] - fc), 64'd1);
            chk($sformatf("overflow[%0d]", k), 64'(ovf_cnt[0]), 64'(vecs[k].ovf));
            chk($sformatf("busy_len[%0d]", k), 64'(busy_len[0]), 64'd204);
            repeat (5) @(posedge clk);
        end

        // collision: second send at E0+50 is dropped
        fc = frame_cnt[0];
        dc = drop_cnt[0];
        send_on(0, 32'h0000_1000);
        repeat (49) @(posedge clk);
        #1;
        send_v[0] = 1'b1; sample_v[0] = 32'h0000_7000;
        @(posedge clk); #1;
        send_v[0] = 1'b0;
        chk("dropped_pulse", {63'd0, drop_v[0]}, 64'd1);
        wait_done(0, "collision");
        // send inside the frame_done cycle is accepted
        send_v[0] = 1'b1; sample_v[0] = 32'h0000_2000;
        @(posedge clk); #1;
        send_v[0] = 1'b0;
        chk("busy_on_done_cycle_send", {63'd0, busy_v[0]}, 64'd1);
        chk("collision_frame", {40'd0, last_frame[0]}, 64'h318400);
        chk("collision_frame_cnt", 64'(frame_cnt[0] - fc), 64'd1);
        wait_done(0, "done_cycle_send");
        repeat (2) @(posedge clk);
        #1;
        chk("done_cycle_frame", {40'd0, last_frame[0]}, 64'h318800);
        chk("drop_count", 64'(drop_cnt[0] - dc), 64'd1);

        // reset mid-frame after 10 falling edges
        repeat (5) @(posedge clk);
        send_on(0, 32'h0000_4000);
        begin
            bit hit = 0;
            for (int c = 0; c < 400; c++) begin
                @(posedge clk); #1;
                if (nbits[0] >= 10) begin hit = 1; break; end
            end
            chk("reach_10_edges", {63'd0, hit}, 64'd1);
        end
        fc = frame_cnt[0];
        #2 rstn = 1'b0;
        #1;
        chk("async_reset_outputs", {60'd0, cs_v[0], sclk_v[0], data_v[0], busy_v[0]}, 64'b1100);
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        send_on(0, 32'h0000_0000);
        wait_done(0, "after_reset");
        repeat (2) @(posedge clk);
        #1;
        chk("after_reset_frame", {40'd0, last_frame[0]}, 64'h318000);
        chk("after_reset_frame_cnt", 64'(frame_cnt[0] - fc), 64'd1);

        // edge discipline with CLK_DIV=1 and 7 on random samples
        for (int i = 1; i < 3; i++) begin
            for (int k = 0; k < 6; k++) begin
                v = $urandom;
                if (k == 0) v = v >>> 12;
                send_on(i, v);
                wait_done(i, $sformatf("rand_div%0d_%0d", cd_of(i), k));
                repeat (2) @(posedge clk);
                #1;
                chk($sformatf("rand_frame_div%0d_%0d", cd_of(i), k), {40'd0, last_frame[i]}, {40'd0, ref_frame(v)});
            end
            chk($sformatf("edge_violations_div%0d", cd_of(i)), 64'(viol[i]), 64'd0);
        end
        chk("edge_violations_div4", 64'(viol[0]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_sample_serializer.md
# dac_sample_serializer

Output stage between the harmonic accumulator and the MAX5134 DAC. It takes one signed 32-bit accumulated sample per sample period and converts it to a saturated 16-bit offset-binary code. It prefixes the DAC command byte and shifts the resulting 24-bit frame out over SPI. Overflow and dropped-sample flags are pulsed for debug.

## Interface
- CLK_DIV, 4: fpga_clock cycles per SCLK half-period; legal range 1..255.
- CMD, 8'b00110001: DAC command byte (write channel A), sent first.
- OUT_SHIFT, 2: arithmetic right shift applied to the input before offsetting.
- fpga_clock  in  1  system clock (72 MHz PLL output); all logic on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- sample_in  in  32  signed accumulated sample; sampled only on an accepted send.
- send  in  1  single-cycle request to transmit sample_in.
- busy  out  1  high from the cycle after acceptance until the frame completes; reset 0.
- frame_done  out  1  one-cycle pulse on return to IDLE; reset 0.
- overflow  out  1  one-cycle pulse, the cycle after acceptance, if the code saturated; reset 0.
- dropped  out  1  one-cycle pulse, the cycle after a send arrives while busy; reset 0.
- spi_cs_out  out  1  active-low chip select; reset 1.
- spi_clock_out  out  1  SCLK, idles high; reset 1.
- spi_data_out  out  1  MOSI, MSB first; reset 0.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE -> SETUP when send=1.
  - On that edge, latch frame = {CMD, code}.
  - code = sat16((sample_in >>> OUT_SHIFT) + 32768).
  - The sum is computed in at least 34 bits signed.
  - sat16 clamps below 0 to 0x0000 and above 65535 to 0xFFFF, and sets overflow when a clamp occurs.
- SETUP: cs low, SCLK high, data = frame[23]. Lasts CLK_DIV cycles, then -> SHIFT.
- SHIFT: 24 bit periods of 2*CLK_DIV cycles each.
  - First half: SCLK high, data holds the current bit.
  - Second half: SCLK low. The falling edge at the half-way point is the DAC latch edge.
  - Data changes only while SCLK is high, at the start of each bit period; never at a falling edge.
  - After bit 0's low half -> HOLD.
- HOLD: SCLK high, cs low, CLK_DIV cycles -> GAP.
- GAP: cs high, data 0, CLK_DIV cycles -> IDLE. frame_done pulses in the first IDLE cycle.
- send while not IDLE:
  - Ignored; the frame in flight is unaffected.
  - dropped pulses.
  - No queueing.
- send in the same cycle that frame_done is high: accepted (state is IDLE).
- sample_in changes after acceptance have no effect on the frame.
- rstn low at any time, including mid-frame:
  - Outputs go immediately to their reset values (cs 1, SCLK 1, data 0, flags 0).
  - State returns to IDLE.
  - The partial frame is abandoned; the DAC discards it because cs rises before bit 24.

## Timing
- Send sampled at edge E0. busy and cs low are visible after E0.
- SCLK first falling edge: E0 + 2*CLK_DIV.
- Last (24th) falling edge: E0 + 48*CLK_DIV.
- cs rises at E0 + 50*CLK_DIV.
- frame_done high and busy low at E0 + 51*CLK_DIV.
- With CLK_DIV=4: frame = 204 cycles and SCLK = 9 MHz. This fits well within the 1500-cycle sample interval; faster SCLK (<=30 MHz) stays within MAX5134 limits.
- Minimum cs-high time between frames: CLK_DIV cycles.
- overflow and dropped are never asserted for more than one cycle per event.

## Test plan
- Zero sample: sample_in=0, send -> captured frame 0x318000 on 24 falling edges, overflow 0, busy high for exactly 204 cycles (CLK_DIV=4), frame_done one pulse.
- Full scale: sample_in=0x0001FFFC -> frame 0x31FFFF, overflow 0. Then sample_in=0x00020000 -> frame 0x31FFFF, overflow pulses once.
- Negative limit: sample_in=-0x20000 -> frame 0x310000, overflow 0. Then sample_in=-0x20004 -> frame 0x310000, overflow pulses. Then 0x80000000 -> frame 0x310000, overflow pulses.
- Busy collision: send at E0 with 0x1000, send again at E0+50 with 0x7000 -> single frame 0x318400, dropped pulses once at E0+51. A send in the frame_done cycle starts a new frame immediately.
- Reset mid-frame: rstn low after 10 falling edges -> cs 1, SCLK 1, data 0, busy 0 asynchronously (same cycle). After release, send 0 -> clean 0x318000 frame.
- Edge discipline: CLK_DIV=1 and CLK_DIV=7 with random samples -> spi_data_out never changes within one cycle of a falling SCLK edge. The checker model recovers all frames bit-exact against the sat16 reference.
